// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers of the RISC-V core:
// the NOP encoding used as the IF/ID bubble, the IF/ID payload layout, and
// the state encoding of the optional skid FSM (PIPE_STAGE_SKID_EN builds).
package pipe_pkg;

    // addi x0, x0, 0 -- the canonical RISC-V NOP
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    // IF/ID payload layout: {pc+4, pc, instruction}
    localparam int unsigned IFID_FIELD_W   = 32;
    localparam int unsigned IFID_DATA_W    = 96;
    localparam int unsigned IFID_INSTR_LSB = 0;
    localparam int unsigned IFID_PC_LSB    = 32;
    localparam int unsigned IFID_PC4_LSB   = 64;

    // Skid FSM occupancy: nothing held, main only, main plus skid
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    // Packs the IF/ID fields at their fixed offsets
    function automatic logic [IFID_DATA_W-1:0] ifid_pack(
        input logic [IFID_FIELD_W-1:0] instr,
        input logic [IFID_FIELD_W-1:0] pc,
        input logic [IFID_FIELD_W-1:0] pc4
    );
        return {pc4, pc, instr};
    endfunction

    // IF/ID bubble: a NOP with zero pc fields
    localparam logic [IFID_DATA_W-1:0] IFID_BUBBLE = {32'h00000000, 32'h00000000, NOP_INSTR};

endpackage

// File: rtl/pipe_skid_slot.sv
// One payload register with a load enable. Used for both the main (output)
// register and the skid register so the control FSM stays apart from the
// datapath. Reset loads RST_VAL, normally the bubble pattern.
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int unsigned          DATA_W  = 96,
    parameter logic [DATA_W-1:0]    RST_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] slot_d;
    logic [DATA_W-1:0] slot_q;

    // Next value: new payload when loading, otherwise hold
    always_comb begin
        slot_d = slot_q;
        if (load) begin
            slot_d = d;
        end else begin
            slot_d = slot_q;
        end
    end

    // Payload flop with synchronous reset to the configured value
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q <= RST_VAL;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign q = slot_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and bubble
// insertion. out_data always shows BUBBLE_DATA when out_valid is low, so
// downstream may decode it unconditionally.
//
// Build option PIPE_STAGE_SKID_EN:
//   undefined - single register, in_ready combinational from out_ready.
//   defined   - main + skid register with a small FSM; in_ready is a
//               decode of registered state, breaking the stall path.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W      = 96,
    parameter logic [DATA_W-1:0] BUBBLE_DATA = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic              accept_s;
    logic              main_load_s;
    logic [DATA_W-1:0] main_d_s;
    logic [DATA_W-1:0] main_q_s;

    // Output register; reset leaves the bubble on out_data
    pipe_skid_slot #(
        .DATA_W  (DATA_W),
        .RST_VAL (BUBBLE_DATA)
    ) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (main_load_s),
        .d     (main_d_s),
        .q     (main_q_s)
    );

    assign out_data = main_q_s;

`ifdef PIPE_STAGE_SKID_EN

    skid_state_e       state_d;
    skid_state_e       state_q;
    logic              skid_load_s;
    logic [DATA_W-1:0] skid_d_s;
    logic [DATA_W-1:0] skid_q_s;

    // Second register absorbing the one beat in flight when out_ready drops
    pipe_skid_slot #(
        .DATA_W  (DATA_W),
        .RST_VAL (BUBBLE_DATA)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load_s),
        .d     (skid_d_s),
        .q     (skid_q_s)
    );

    // Handshake outputs decoded purely from registered state
    assign in_ready  = (state_q != SKID_FULL);
    assign out_valid = (state_q != SKID_EMPTY);
    assign accept_s  = in_valid && in_ready && !flush;

    // Occupancy FSM and register load controls; main always holds the older beat
    always_comb begin
        state_d     = state_q;
        main_load_s = 1'b0;
        main_d_s    = in_data;
        skid_load_s = 1'b0;
        skid_d_s    = in_data;
        if (flush) begin
            state_d     = SKID_EMPTY;
            main_load_s = 1'b1;
            main_d_s    = BUBBLE_DATA;
            skid_load_s = 1'b1;
            skid_d_s    = BUBBLE_DATA;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (accept_s) begin
                        state_d     = SKID_ONE;
                        main_load_s = 1'b1;
                        main_d_s    = in_data;
                    end else begin
                        state_d = SKID_EMPTY;
                    end
                end
                SKID_ONE: begin
                    if (accept_s && out_ready) begin
                        state_d     = SKID_ONE;
                        main_load_s = 1'b1;
                        main_d_s    = in_data;
                    end else if (accept_s) begin
                        state_d     = SKID_FULL;
                        skid_load_s = 1'b1;
                        skid_d_s    = in_data;
                    end else if (out_ready) begin
                        state_d     = SKID_EMPTY;
                        main_load_s = 1'b1;
                        main_d_s    = BUBBLE_DATA;
                    end else begin
                        state_d = SKID_ONE;
                    end
                end
                SKID_FULL: begin
                    if (out_ready) begin
                        state_d     = SKID_ONE;
                        main_load_s = 1'b1;
                        main_d_s    = skid_q_s;
                        skid_load_s = 1'b1;
                        skid_d_s    = BUBBLE_DATA;
                    end else begin
                        state_d = SKID_FULL;
                    end
                end
                default: begin
                    state_d     = SKID_EMPTY;
                    main_load_s = 1'b1;
                    main_d_s    = BUBBLE_DATA;
                    skid_load_s = 1'b1;
                    skid_d_s    = BUBBLE_DATA;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SKID_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

`else

    logic out_valid_d;
    logic out_valid_q;
    logic consume_s;

    // Stage can take a beat when empty or when the held beat leaves this cycle
    assign in_ready  = !out_valid_q || out_ready;
    assign out_valid = out_valid_q;
    assign accept_s  = in_valid && in_ready && !flush;
    assign consume_s = out_valid_q && out_ready;

    // Valid and payload update: flush, then accept, then consume-to-bubble
    always_comb begin
        out_valid_d = out_valid_q;
        main_load_s = 1'b0;
        main_d_s    = BUBBLE_DATA;
        if (flush) begin
            out_valid_d = 1'b0;
            main_load_s = 1'b1;
            main_d_s    = BUBBLE_DATA;
        end else if (accept_s) begin
            out_valid_d = 1'b1;
            main_load_s = 1'b1;
            main_d_s    = in_data;
        end else if (consume_s) begin
            out_valid_d = 1'b0;
            main_load_s = 1'b1;
            main_d_s    = BUBBLE_DATA;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Valid flop
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
        end
    end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg configured as the IF/ID stage. A queue holds the
// beats the stage owns; its head is what must be on out_data.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int unsigned       DATA_W = IFID_DATA_W;
    localparam logic [DATA_W-1:0] BUBBLE = ifid_pack(NOP_INSTR, 32'h00000000, 32'h00000000);
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    logic [DATA_W-1:0] mq[$];
    bit                model_known;
    int                n_checks;
    int                n_pass;

    pipe_stage_reg #(
        .DATA_W      (DATA_W),
        .BUBBLE_DATA (BUBBLE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [DATA_W-1:0] act,
                                input logic [DATA_W-1:0] exp);
        n_checks = n_checks + 1;
        if (act === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // One clock: drive inputs, compare DUT with the model mid-cycle, advance the model
    task automatic cycle(input logic r, input logic f, input logic v,
                         input logic [DATA_W-1:0] d, input logic ordy);
        logic exp_rdy;
        reset     = r;
        flush     = f;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        @(negedge clk);
`ifdef PIPE_STAGE_SKID_EN
        exp_rdy = (mq.size() < CAP);
`else
        exp_rdy = (mq.size() == 0) || ordy;
`endif
        if (model_known) begin
            chk("model_out_valid", {{(DATA_W-1){1'b0}}, out_valid}, {{(DATA_W-1){1'b0}}, mq.size() != 0});
            chk("model_out_data", out_data, (mq.size() != 0) ? mq[0] : BUBBLE);
            chk("model_in_ready", {{(DATA_W-1){1'b0}}, in_ready}, {{(DATA_W-1){1'b0}}, exp_rdy});
        end
        @(posedge clk);
        if (r) begin
            mq.delete();
            model_known = 1'b1;
        end else if (f) begin
            mq.delete();
        end else begin
            if (mq.size() != 0 && ordy) void'(mq.pop_front());
            if (v && exp_rdy) mq.push_back(d);
        end
        #1;
    endtask

    function automatic logic [DATA_W-1:0] w1(input logic b);
        return {{(DATA_W-1){1'b0}}, b};
    endfunction

    initial begin
        logic [DATA_W-1:0] rd;
        n_checks    = 0;
        n_pass      = 0;
        model_known = 1'b0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset for two cycles, the second with flush and a beat present
        cycle(1'b1, 1'b0, 1'b0, 96'h0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 96'hDEAD, 1'b0);
        chk("rst_out_valid", w1(out_valid), 96'h0);
        chk("rst_out_data", out_data, {64'h0, 32'h00000013});
        chk("rst_instr_field", {64'h0, out_data[31:0]}, {64'h0, 32'h00000013});
        chk("rst_in_ready", w1(in_ready), 96'h1);

        // Stream 1..8 with out_ready high: each beat visible right after its edge
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, 1'b0, 1'b1, DATA_W'(i), 1'b1);
            chk("stream_data", out_data, DATA_W'(i));
            chk("stream_valid", w1(out_valid), 96'h1);
        end
        cycle(1'b0, 1'b0, 1'b0, 96'h0, 1'b1);
        chk("drain_valid", w1(out_valid), 96'h0);
        chk("drain_bubble", out_data, {64'h0, 32'h00000013});

`ifdef PIPE_STAGE_SKID_EN
        // A accepted, out_ready drops while B then C are offered
        cycle(1'b0, 1'b0, 1'b1, 96'hA, 1'b1);
        chk("skid_a", out_data, 96'hA);
        cycle(1'b0, 1'b0, 1'b1, 96'hB, 1'b0);
        chk("skid_full_rdy", w1(in_ready), 96'h0);
        chk("skid_hold_a", out_data, 96'hA);
        cycle(1'b0, 1'b0, 1'b1, 96'hC, 1'b0);
        chk("skid_hold_a2", out_data, 96'hA);
        cycle(1'b0, 1'b0, 1'b1, 96'hC, 1'b1);
        chk("skid_b", out_data, 96'hB);
        cycle(1'b0, 1'b0, 1'b1, 96'hC, 1'b1);
        chk("skid_c", out_data, 96'hC);
        cycle(1'b0, 1'b0, 1'b0, 96'h0, 1'b1);
        chk("skid_empty", w1(out_valid), 96'h0);
`else
        // Single register: B waits upstream until A is consumed
        cycle(1'b0, 1'b0, 1'b1, 96'hA, 1'b1);
        chk("bp_a", out_data, 96'hA);
        cycle(1'b0, 1'b0, 1'b1, 96'hB, 1'b0);
        chk("bp_rdy_low", w1(in_ready), 96'h0);
        chk("bp_hold_a", out_data, 96'hA);
        cycle(1'b0, 1'b0, 1'b1, 96'hB, 1'b1);
        chk("bp_b", out_data, 96'hB);
        cycle(1'b0, 1'b0, 1'b0, 96'h0, 1'b1);
        chk("bp_empty", w1(out_valid), 96'h0);
`endif

        // Fill the stage, then flush with 0xD on the input
        cycle(1'b0, 1'b0, 1'b1, 96'h11, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 96'h12, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 96'hD, 1'b0);
        chk("flush_valid", w1(out_valid), 96'h0);
        chk("flush_bubble", out_data, {64'h0, 32'h00000013});
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 96'h0, 1'b1);
            chk("flush_no_d", w1(out_valid), 96'h0);
        end

        // Backpressure for 5 cycles holds 0x55 stable
        cycle(1'b0, 1'b0, 1'b1, 96'h55, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 96'h0, 1'b0);
            chk("hold_data", out_data, 96'h55);
            chk("hold_valid", w1(out_valid), 96'h1);
        end
        cycle(1'b0, 1'b0, 1'b0, 96'h0, 1'b1);

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 1500; i++) begin
            rd = {$urandom, $urandom, $urandom};
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 3) != 0, rd, $urandom_range(0, 3) != 0);
        end

        // Reset together with flush and a valid beat while holding data
        cycle(1'b0, 1'b0, 1'b1, 96'h77, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 96'hBEEF, 1'b1);
        chk("rst2_out_valid", w1(out_valid), 96'h0);
        chk("rst2_out_data", out_data, {64'h0, 32'h00000013});
        chk("rst2_in_ready", w1(in_ready), 96'h1);
        cycle(1'b0, 1'b0, 1'b0, 96'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with valid/ready handshake, flush and bubble insertion. Replaces fixed-width, write-enable-only inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) in the pipelined RISC-V core. Payload is an opaque bit vector packed by the instantiating stage. An optional skid slot registers the upstream ready so that no stall path is combinational through the stage.

## Interface
- DATA_W, 96: payload width in bits. The IF/ID packing is instruction, pc, pc+4.
- BUBBLE_DATA, {DATA_W{1'b0}}: value driven on out_data when the stage holds no valid beat. IF/ID uses the NOP encoding from the package.

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  discard every held beat, synchronous.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage accepts a beat this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data holds a valid beat.
- out_ready  in  1  downstream consumes the beat this cycle.
- out_data  out  DATA_W  payload to the next stage.

## Operation
- Accept: in_valid && in_ready && !flush.
- Consume: out_valid && out_ready.
- Single-register mode (macro absent):
  - in_ready = !out_valid || out_ready. This path is combinational from out_ready.
  - On accept, out_data <= in_data and out_valid <= 1.
  - On consume without accept, out_valid <= 0 and out_data <= BUBBLE_DATA.
  - Otherwise, hold.
- Skid mode (macro present) uses a main register and a skid register.
  - States:
    - EMPTY: no valid beat.
    - ONE: main register valid.
    - FULL: main and skid valid.
  - in_ready = (state != FULL). It is a direct decode of registered state, with no combinational dependence on out_ready.
  - EMPTY: accept -> ONE, main <= in_data.
  - ONE:
    - accept && out_ready -> ONE, main <= in_data.
    - accept && !out_ready -> FULL, skid <= in_data.
    - !accept && out_ready -> EMPTY.
    - Otherwise, hold.
  - FULL:
    - out_ready -> ONE, main <= skid.
    - Otherwise, hold.
  - Beat order is always preserved: main before skid.
- Flush has priority over accept and consume, in either mode.
  - Next cycle: state EMPTY, out_valid 0, out_data BUBBLE_DATA.
  - The in_data beat in the flush cycle is dropped, even though in_ready may read 1. Upstream treats it as consumed.
- Reset has priority over flush and gives the same result as flush.
- out_data always reads BUBBLE_DATA whenever out_valid is 0. Downstream may decode it unconditionally.
- No arithmetic. Payload bits pass unmodified.

## Timing
- Reset values:
  - out_valid 0.
  - out_data BUBBLE_DATA.
  - in_ready 1, in both modes, because the stage is EMPTY and out_valid is 0.
- Latency: a beat accepted at edge N is visible on out_data / out_valid after edge N. This is 1 cycle in both modes.
- Throughput: 1 beat/cycle while out_ready is held at 1.
- Skid mode absorbs exactly one extra beat after out_ready falls. in_ready deasserts the cycle after the stage reaches FULL.
- Simultaneous accept and consume in ONE keeps the stage in ONE with no bubble.
- Holding out_ready at 0 holds out_data stable indefinitely.

## Configuration
- PIPE_STAGE_SKID_EN
  - Defined: skid register and FSM are compiled in; in_ready is registered.
  - Undefined: single-register mode, with combinational in_ready. Area is one DATA_W register plus one valid flop.
- Port list and parameters are identical in both modes.

## Structure
- Package pipe_pkg holds:
  - the NOP instruction constant 32'h00000013;
  - the IF/ID payload width (96);
  - the field offset constants for instruction, pc and pc+4;
  - the skid FSM state enum (EMPTY, ONE, FULL).
- Optional sub-module pipe_skid_slot: one DATA_W register with a load enable. It is instantiated for the main and skid registers to keep the FSM separate from the datapath.

## Test plan
- Reset asserted for 2 cycles, then released:
  - out_valid 0.
  - out_data BUBBLE_DATA (32'h00000013 in the instruction field).
  - in_ready 1.
- Stream 8 beats (0x1..0x8) with out_ready held at 1:
  - each beat appears 1 cycle after acceptance;
  - no gaps;
  - order preserved.
- In skid mode, accept 0xA, then drop out_ready while presenting 0xB and 0xC:
  - 0xB is absorbed and in_ready falls;
  - 0xC is held upstream;
  - on raising out_ready, the output is 0xA, 0xB, 0xC in consecutive cycles.
- Flush in FULL state with in_valid = 1 and in_data = 0xD:
  - next cycle out_valid 0 and out_data BUBBLE_DATA;
  - 0xD never appears at the output.
- Hold out_ready at 0 for 5 cycles with a valid beat 0x55: out_data stays 0x55 and out_valid stays 1.
- Assert reset together with flush and in_valid: the result matches the post-reset values above.
